// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-subset core: register-file geometry and word width.
package mips_pkg;
   localparam int REG_COUNT = 32;
   localparam int REG_ADDR_W = 5;
   localparam int WORD_W = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_if.sv
// Write-back and decode-stage connection to the register file: one write port, two read ports.
interface reg_file_if
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W
);
   logic                  we;
   logic [REG_ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]      wdata;
   logic [REG_ADDR_W-1:0] raddr_a;
   logic [REG_ADDR_W-1:0] raddr_b;
   logic [WIDTH-1:0]      rdata_a;
   logic [WIDTH-1:0]      rdata_b;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b,
      input  rdata_a, rdata_b
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b,
      output rdata_a, rdata_b
   );
endinterface

// File: rtl/dec5to32.sv
// One-hot write decoder with enable; bit 0 never asserts so $zero cannot be written.
module dec5to32
   import mips_pkg::*;
(
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] addr,
   output logic [REG_COUNT-1:0]  onehot
);
   always_comb begin
      // NOTE: default every output first so no path leaves it unassigned and infers a latch.
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
      onehot[0] = 1'b0;
   end
endmodule

// File: rtl/mux32to1.sv
// 32-way read-select multiplexer, one per register-file read port.
module mux32to1
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0]      d [REG_COUNT],
   input  logic [REG_ADDR_W-1:0] sel,
   output logic [WIDTH-1:0]      y
);
   assign y = d[sel];
endmodule

// File: rtl/reg_file.sv
// 32x32 register file: r0 hard-wired to zero, synchronous write, combinational
// reads with same-cycle write-to-read bypass on each port.
module reg_file
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic       clk,
   input  logic       rst_n,
   reg_file_if.slave  bus
);
   logic [REG_COUNT-1:0] wr_en;
   logic [WIDTH-1:0]     store [1:REG_COUNT-1];
   logic [WIDTH-1:0]     mux_in [REG_COUNT];
   logic [WIDTH-1:0]     mux_a;
   logic [WIDTH-1:0]     mux_b;
   logic                 byp_a;
   logic                 byp_b;

   dec5to32 u_dec (
      .en     (bus.we),
      .addr   (bus.waddr),
      .onehot (wr_en)
   );

   // NOTE: storage is flops, not RAM, so clearing it on async reset is legal and required.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < REG_COUNT; i++) store[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_en[i]) store[i] <= bus.wdata;
         end
      end
   end

   always_comb begin
      mux_in[0] = '0;
      for (int i = 1; i < REG_COUNT; i++) mux_in[i] = store[i];
   end

   mux32to1 #(.WIDTH(WIDTH)) u_mux_a (
      .d   (mux_in),
      .sel (bus.raddr_a),
      .y   (mux_a)
   );

   mux32to1 #(.WIDTH(WIDTH)) u_mux_b (
      .d   (mux_in),
      .sel (bus.raddr_b),
      .y   (mux_b)
   );

   // Bypass stays live during reset because the read path never sees rst_n.
   assign byp_a = bus.we && (bus.waddr == bus.raddr_a) && (bus.raddr_a != ZERO_REG);
   assign byp_b = bus.we && (bus.waddr == bus.raddr_b) && (bus.raddr_b != ZERO_REG);

   assign bus.rdata_a = byp_a ? bus.wdata : mux_a;
   assign bus.rdata_b = byp_b ? bus.wdata : mux_b;
endmodule
